// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester-side and memory-side handshake signals of the shared
// backing-memory port. The arbiter takes the slave view; requesters plus the
// memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CL_SIZE = 128
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_is_write;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*CL_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0]         req_ready;

    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [ADDR_W-1:0]          mem_addr;
    logic                       mem_is_write;
    logic [CL_SIZE-1:0]         mem_wdata;
    logic                       mem_resp_valid;
    logic [CL_SIZE-1:0]         mem_resp_data;

    logic [NUM_REQ-1:0]         resp_valid;
    logic [CL_SIZE-1:0]         resp_data;
    logic                       resp_err;
    logic                       busy;

    modport master (
        output req_valid, req_is_write, req_addr, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, mem_req_valid, mem_addr, mem_is_write, mem_wdata,
        input  resp_valid, resp_data, resp_err, busy
    );

    modport slave (
        input  req_valid, req_is_write, req_addr, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, mem_req_valid, mem_addr, mem_is_write, mem_wdata,
        output resp_valid, resp_data, resp_err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between the I$ even bank, I$ odd bank and
// D$ miss requesters. Round-robin grant, one transaction in flight, response
// routed back to the owner, timeout guard while waiting on memory.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CL_SIZE = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     owner_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 is_write_q;
    logic [CL_SIZE-1:0]   wdata_q;
    logic [CL_SIZE-1:0]   resp_data_q;
    logic                 resp_err_q;

    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [CL_SIZE-1:0]   sel_wdata;
    int unsigned          scan;
    logic [PTR_W-1:0]     scan_idx;
    logic                 timeout_hit;

    assign timeout_hit = (cnt_q == CNT_LAST);

    // Round-robin pick: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = 32'(rr_ptr_q) + i;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            scan_idx = PTR_W'(scan);
            if (!grant_valid && bus.req_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Select the granted requester's address and writeback line.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*CL_SIZE +: CL_SIZE];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a memory response beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_valid) state_d = ST_ISSUE;
            ST_ISSUE: if (bus.mem_req_ready) state_d = ST_WAIT;
            ST_WAIT:  if (bus.mem_resp_valid || timeout_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request latch, wait counter, response capture and pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            is_write_q  <= 1'b0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_q    <= grant_idx;
                        addr_q     <= sel_addr;
                        is_write_q <= bus.req_is_write[grant_idx];
                        wdata_q    <= sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        cnt_q <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.mem_resp_valid) begin
                        resp_data_q <= bus.mem_resp_data;
                        resp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    rr_ptr_q <= (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and latched fields; req_ready held low in reset.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == ST_IDLE && grant_valid && !rst) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
        bus.mem_req_valid = (state_q == ST_ISSUE);
        bus.mem_addr      = addr_q;
        bus.mem_is_write  = is_write_q;
        bus.mem_wdata     = wdata_q;
        bus.resp_valid    = '0;
        if (state_q == ST_RESP) begin
            bus.resp_valid[owner_q] = 1'b1;
        end
        bus.resp_data = resp_data_q;
        bus.resp_err  = resp_err_q;
        bus.busy      = (state_q != ST_IDLE);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (pending requests, round-robin pointer,
// response latency vs. timeout).
module tb_mem_port_arbiter;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 128;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .CL_SIZE(CW)) bus ();

    mem_port_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .CL_SIZE(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ptr     = 0;

    logic          pend_v    [NR];
    logic [AW-1:0] pend_addr [NR];
    logic          pend_w    [NR];
    logic [CW-1:0] pend_data [NR];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid      = '0;
        bus.req_is_write   = '0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    function automatic logic [CW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NR-1:0] onehot(input int idx);
        return NR'(1) << idx;
    endfunction

    // Model: first pending requester scanning from the pointer.
    function automatic int exp_grant(input int ptr);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (pend_v[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        logic [NR-1:0]    v;
        logic [NR-1:0]    w;
        logic [NR*AW-1:0] a;
        logic [NR*CW-1:0] d;
        v = '0; w = '0; a = '0; d = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            v = (v << 1) | NR'(pend_v[i]);
            w = (w << 1) | NR'(pend_w[i]);
            a = (a << AW) | (NR*AW)'(pend_addr[i]);
            d = (d << CW) | (NR*CW)'(pend_data[i]);
        end
        bus.req_valid    = v;
        bus.req_is_write = w;
        bus.req_addr     = a;
        bus.req_wdata    = d;
    endtask

    task automatic test_reset();
        logic [9:0] ctl;
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        ctl = {bus.req_ready, bus.mem_req_valid, bus.mem_is_write, bus.resp_valid, bus.resp_err, bus.busy};
        vectors++;
        if (ctl !== '0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b expected 0", ctl);
        end
        vectors++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.resp_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wdata=%h resp=%h expected all 0", bus.mem_addr, bus.mem_wdata, bus.resp_data);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        vectors++;
        if (bus.busy !== 1'b0 || bus.req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b req_ready=%b expected 0/000", bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_single_read();
        logic [CW-1:0] a5;
        a5 = {16{8'hA5}};
        apply_reset();
        bus.req_valid = 3'b001;
        bus.req_addr = {64'h0, 32'h0000_1000};
        bus.mem_req_ready = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 3'b001 || bus.mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_T0: req_ready=%b mem_req_valid=%b expected 001/0", bus.req_ready, bus.mem_req_valid);
        end
        next_cycle();
        bus.req_valid = '0;
        #1;
        vectors++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h1000 || bus.mem_is_write !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_T1: valid=%b addr=%h wr=%b expected 1/00001000/0", bus.mem_req_valid, bus.mem_addr, bus.mem_is_write);
        end
        next_cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = a5;
        #1;
        vectors++;
        if (bus.mem_req_valid !== 1'b0 || bus.busy !== 1'b1 || bus.resp_valid !== '0) begin
            miscompares++;
            $display("FAIL rd_T2: valid=%b busy=%b resp_valid=%b expected 0/1/000", bus.mem_req_valid, bus.busy, bus.resp_valid);
        end
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        #1;
        vectors++;
        if (bus.resp_valid !== 3'b001 || bus.resp_data !== a5 || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_T3: resp_valid=%b data=%h err=%b expected 001/%h/0", bus.resp_valid, bus.resp_data, bus.resp_err, a5);
        end
        next_cycle();
        bus.req_valid = 3'b010;
        #1;
        vectors++;
        if (bus.resp_valid !== '0 || bus.busy !== 1'b0 || bus.resp_data !== a5 || bus.req_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL rd_T4: resp_valid=%b busy=%b data=%h req_ready=%b expected 000/0/%h/010",
                     bus.resp_valid, bus.busy, bus.resp_data, bus.req_ready, a5);
        end
    endtask

    task automatic test_round_robin();
        int want [4] = '{0, 1, 2, 0};
        logic [CW-1:0] rd;
        apply_reset();
        bus.req_valid = 3'b111;
        bus.req_addr = {32'h300, 32'h200, 32'h100};
        bus.mem_req_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            vectors++;
            if (bus.req_ready !== onehot(want[n])) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: req_ready=%b expected %b", n, bus.req_ready, onehot(want[n]));
            end
            next_cycle();
            vectors++;
            if (bus.mem_addr !== 32'(32'h100 * (want[n] + 1))) begin
                miscompares++;
                $display("FAIL rr_addr[%0d]: mem_addr=%h expected %h", n, bus.mem_addr, 32'h100 * (want[n] + 1));
            end
            next_cycle();
            rd = rand_line();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data = rd;
            next_cycle();
            bus.mem_resp_valid = 1'b0;
            #1;
            vectors++;
            if (bus.resp_valid !== onehot(want[n]) || bus.resp_data !== rd) begin
                miscompares++;
                $display("FAIL rr_resp[%0d]: resp_valid=%b data=%h expected %b/%h", n, bus.resp_valid, bus.resp_data, onehot(want[n]), rd);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] wd, rd;
        wd = rand_line();
        rd = rand_line();
        apply_reset();
        bus.req_valid = 3'b010;
        bus.req_is_write = 3'b010;
        bus.req_addr = {32'h0, 32'h3000, 32'h0};
        bus.req_wdata = {128'h0, wd, 128'h0};
        #1;
        vectors++;
        if (bus.req_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_grant: req_ready=%b expected 010", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 3'b101;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (bus.mem_req_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== '0 ||
                bus.mem_addr !== 32'h3000 || bus.mem_wdata !== wd || bus.mem_is_write !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid=%b busy=%b ready=%b addr=%h wr=%b wdata=%h expected 1/1/000/00003000/1/%h",
                         c, bus.mem_req_valid, bus.busy, bus.req_ready, bus.mem_addr, bus.mem_is_write, bus.mem_wdata, wd);
            end
            next_cycle();
        end
        bus.req_valid = '0;
        bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = rd;
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (bus.resp_valid !== 3'b010 || bus.resp_data !== rd || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_resp: resp_valid=%b data=%h err=%b expected 010/%h/0", bus.resp_valid, bus.resp_data, bus.resp_err, rd);
        end
    endtask

    task automatic test_writeback();
        logic [CW-1:0] wd, ack;
        wd = {4{32'hDEAD_BEEF}};
        ack = rand_line();
        apply_reset();
        bus.req_valid = 3'b100;
        bus.req_is_write = 3'b100;
        bus.req_addr = {32'h2040, 64'h0};
        bus.req_wdata = {wd, 256'h0};
        #1;
        vectors++;
        if (bus.req_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL wb_grant: req_ready=%b expected 100", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = '0;
        bus.mem_req_ready = 1'b1;
        #1;
        vectors++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_is_write !== 1'b1 || bus.mem_addr !== 32'h2040 || bus.mem_wdata !== wd) begin
            miscompares++;
            $display("FAIL wb_issue: valid=%b wr=%b addr=%h wdata=%h expected 1/1/00002040/%h",
                     bus.mem_req_valid, bus.mem_is_write, bus.mem_addr, bus.mem_wdata, wd);
        end
        next_cycle();
        bus.mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (bus.resp_valid !== '0 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL wb_wait[%0d]: resp_valid=%b busy=%b expected 000/1", c, bus.resp_valid, bus.busy);
            end
            next_cycle();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = ack;
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (bus.resp_valid !== 3'b100 || bus.resp_err !== 1'b0 || bus.resp_data !== ack) begin
            miscompares++;
            $display("FAIL wb_resp: resp_valid=%b err=%b data=%h expected 100/0/%h", bus.resp_valid, bus.resp_err, bus.resp_data, ack);
        end
        next_cycle();
    endtask

    // Runs straight after the writeback so resp_data starts non-zero.
    task automatic test_timeout();
        logic [CW-1:0] stray;
        stray = rand_line();
        clear_inputs();
        bus.req_valid = 3'b010;
        bus.req_addr = {32'h0, 32'h4400, 32'h0};
        next_cycle();
        bus.req_valid = '0;
        bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < TO; k++) begin
            #1;
            vectors++;
            if (bus.resp_valid !== '0 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL to_wait[%0d]: resp_valid=%b busy=%b expected 000/1", k, bus.resp_valid, bus.busy);
            end
            next_cycle();
        end
        vectors++;
        if (bus.resp_valid !== 3'b010 || bus.resp_err !== 1'b1 || bus.resp_data !== '0) begin
            miscompares++;
            $display("FAIL to_resp: resp_valid=%b err=%b data=%h expected 010/1/0", bus.resp_valid, bus.resp_err, bus.resp_data);
        end
        next_cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = stray;
        next_cycle();
        next_cycle();
        vectors++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== '0 || bus.resp_err !== 1'b1 || bus.resp_data !== '0) begin
            miscompares++;
            $display("FAIL to_stray: busy=%b resp_valid=%b err=%b data=%h expected 0/000/1/0",
                     bus.busy, bus.resp_valid, bus.resp_err, bus.resp_data);
        end
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [9:0] ctl;
        apply_reset();
        bus.req_addr = {32'hC000, 32'hB000, 32'hA000};
        bus.req_valid = 3'b001;
        bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = rand_line();
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        next_cycle();
        bus.req_valid = 3'b010;
        next_cycle();
        bus.req_valid = '0;
        next_cycle();
        bus.mem_req_ready = 1'b0;
        next_cycle();
        #2 rst = 1'b1;
        #1;
        ctl = {bus.req_ready, bus.mem_req_valid, bus.mem_is_write, bus.resp_valid, bus.resp_err, bus.busy};
        vectors++;
        if (ctl !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.resp_data !== '0) begin
            miscompares++;
            $display("FAIL rst_wait: ctl=%b addr=%h wdata=%h resp=%h expected all 0", ctl, bus.mem_addr, bus.mem_wdata, bus.resp_data);
        end
        next_cycle();
        rst = 1'b0;
        bus.req_valid = 3'b101;
        #1;
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_ptr: req_ready=%b expected 001", bus.req_ready);
        end
        bus.req_valid = 3'b100;
        #1;
        vectors++;
        if (bus.req_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL rst_req2: req_ready=%b expected 100", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = '0;
        bus.mem_req_ready = 1'b1;
        #1;
        vectors++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'hC000) begin
            miscompares++;
            $display("FAIL rst_issue: valid=%b addr=%h expected 1/0000c000", bus.mem_req_valid, bus.mem_addr);
        end
        next_cycle();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (bus.resp_valid !== 3'b100 || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_resp: resp_valid=%b err=%b expected 100/0", bus.resp_valid, bus.resp_err);
        end
    endtask

    task automatic test_random();
        int g, bp, lat;
        logic [AW-1:0] a;
        logic          w;
        logic [CW-1:0] d, rd, exp_data, prev_data;
        logic          exp_err, prev_err;
        apply_reset();
        prev_data = '0;
        prev_err = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pend_v[i] = 1'b0; pend_addr[i] = '0; pend_w[i] = 1'b0; pend_data[i] = '0;
        end
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
                    pend_v[i] = 1'b1;
                    pend_addr[i] = $urandom;
                    pend_w[i] = 1'($urandom_range(0, 1));
                    pend_data[i] = rand_line();
                end
            end
            drive_reqs();
            #1;
            g = exp_grant(exp_ptr);
            if (g < 0) begin
                vectors++;
                if (bus.req_ready !== '0 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_idle[%0d]: req_ready=%b busy=%b expected 000/0", t, bus.req_ready, bus.busy);
                end
                next_cycle();
                continue;
            end
            vectors++;
            if (bus.req_ready !== onehot(g) || bus.busy !== 1'b0 || bus.resp_data !== prev_data || bus.resp_err !== prev_err) begin
                miscompares++;
                $display("FAIL rnd_grant[%0d]: req_ready=%b busy=%b data=%h err=%b expected %b/0/%h/%b",
                         t, bus.req_ready, bus.busy, bus.resp_data, bus.resp_err, onehot(g), prev_data, prev_err);
            end
            a = pend_addr[g]; w = pend_w[g]; d = pend_data[g];
            pend_v[g] = 1'b0;
            next_cycle();
            drive_reqs();
            bp = $urandom_range(0, 3);
            for (int c = 0; c <= bp; c++) begin
                if (c == bp) bus.mem_req_ready = 1'b1;
                #1;
                vectors++;
                if (bus.mem_req_valid !== 1'b1 || bus.req_ready !== '0 || bus.mem_addr !== a ||
                    bus.mem_is_write !== w || bus.mem_wdata !== d) begin
                    miscompares++;
                    $display("FAIL rnd_issue[%0d]: valid=%b ready=%b addr=%h wr=%b wdata=%h expected 1/000/%h/%b/%h",
                             t, bus.mem_req_valid, bus.req_ready, bus.mem_addr, bus.mem_is_write, bus.mem_wdata, a, w, d);
                end
                next_cycle();
            end
            bus.mem_req_ready = 1'b0;
            lat = (t % 6 == 0) ? int'(TO) - 1 : int'($urandom_range(0, 10));
            rd = rand_line();
            for (int k = 0; k < TO; k++) begin
                if (k == lat) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data = rd;
                end
                #1;
                vectors++;
                if (bus.mem_req_valid !== 1'b0 || bus.resp_valid !== '0) begin
                    miscompares++;
                    $display("FAIL rnd_wait[%0d.%0d]: mem_req_valid=%b resp_valid=%b expected 0/000", t, k, bus.mem_req_valid, bus.resp_valid);
                end
                next_cycle();
                bus.mem_resp_valid = 1'b0;
                if (k == lat) break;
            end
            exp_err = (lat > int'(TO) - 1);
            exp_data = exp_err ? '0 : rd;
            #1;
            vectors++;
            if (bus.resp_valid !== onehot(g) || bus.resp_data !== exp_data || bus.resp_err !== exp_err) begin
                miscompares++;
                $display("FAIL rnd_resp[%0d]: resp_valid=%b data=%h err=%b expected %b/%h/%b",
                         t, bus.resp_valid, bus.resp_data, bus.resp_err, onehot(g), exp_data, exp_err);
            end
            exp_ptr = (g + 1) % NR;
            prev_data = exp_data;
            prev_err = exp_err;
            next_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_writeback();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
